// File: rtl/icache_nway.sv
// N-way set-associative instruction cache, 16-byte lines, one blocking L2 fill at a time.
// Defining ICACHE_FLUSH_EN adds the flush port and its invalidate logic.
module icache_nway #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic [15:0]  mem_address,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         l2_read,
    output logic [15:0]  l2_address,
    input  logic [127:0] l2_rdata,
    input  logic         l2_resp
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic         flush
`endif
);
    // state | meaning
    // IDLE  | serve hits, launch a fill on a miss
    // FILL  | waiting on L2 for the latched line, CPU request ignored
    localparam int IW = $clog2(SETS);
    localparam int TW = 12 - IW;
    localparam int WW = $clog2(WAYS);
    localparam int PW = (WAYS == 4) ? 3 : 1;

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_nxt;

    logic [SETS-1:0] valid    [WAYS];
    logic [TW-1:0]   tag_arr  [WAYS][SETS];
    logic [127:0]    data_arr [WAYS][SETS];
    logic [PW-1:0]   plru     [SETS];

    logic [11:0]   line_q;
    logic [WW-1:0] victim_q;

    logic [IW-1:0] idx, fill_idx;
    logic [TW-1:0] tag;
    logic [2:0]    word;
    logic          unused_bit;

    assign tag        = mem_address[15:4+IW];
    assign idx        = mem_address[4+IW-1:4];
    assign word       = mem_address[3:1];
    assign fill_idx   = line_q[IW-1:0];
    assign unused_bit = mem_address[0];

    logic          hit;
    logic [WW-1:0] hit_way;
    logic [127:0]  hit_line;

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][idx] && tag_arr[w][idx] == tag) begin
                hit      = 1'b1;
                hit_way  = WW'(w);
                hit_line = data_arr[w][idx];
            end
        end
    end

    assign mem_rdata  = hit_line[{word, 4'b0000} +: 16];
    assign l2_address = {line_q, 4'b0000};

    // Replacement bits point at the least recently used side.
    logic [WW-1:0] plru_way, victim;
    logic [PW-1:0] plru_hit_nxt, plru_fill_nxt;

    generate
        if (WAYS == 4) begin : g_tree
            logic [2:0] cur, fcur;
            assign cur      = plru[idx];
            assign fcur     = plru[fill_idx];
            assign plru_way = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};

            always_comb begin
                plru_hit_nxt    = cur;
                plru_hit_nxt[0] = ~hit_way[1];
                if (hit_way[1]) plru_hit_nxt[2] = ~hit_way[0];
                else            plru_hit_nxt[1] = ~hit_way[0];
            end

            always_comb begin
                plru_fill_nxt    = fcur;
                plru_fill_nxt[0] = ~victim_q[1];
                if (victim_q[1]) plru_fill_nxt[2] = ~victim_q[0];
                else             plru_fill_nxt[1] = ~victim_q[0];
            end
        end else begin : g_bit
            assign plru_way      = plru[idx];
            assign plru_hit_nxt  = ~hit_way;
            assign plru_fill_nxt = ~victim_q;
        end
    endgenerate

    always_comb begin
        victim = plru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][idx]) victim = WW'(w);
        end
    end

    logic do_hit, do_miss, do_fill, flush_now;

    always_comb begin
        state_nxt = state;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        do_fill   = 1'b0;
        mem_resp  = 1'b0;
        l2_read   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        do_hit   = 1'b1;
                    end else begin
                        do_miss   = 1'b1;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                l2_read = 1'b1;
                if (l2_resp) begin
                    do_fill   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ICACHE_FLUSH_EN
    logic flush_pend;
    assign flush_now = (state == IDLE) && (flush || flush_pend);

    // A flush seen mid-fill is deferred until the fill has been written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend <= 1'b0;
        end else if (state == FILL && flush) begin
            flush_pend <= 1'b1;
        end else if (flush_now) begin
            flush_pend <= 1'b0;
        end
    end
`else
    assign flush_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            line_q   <= '0;
            victim_q <= '0;
            for (int w = 0; w < WAYS; w++) valid[w] <= '0;
            for (int s = 0; s < SETS; s++) plru[s] <= '0;
        end else begin
            state <= state_nxt;
            if (do_miss) begin
                line_q   <= {tag, idx};
                victim_q <= victim;
            end
            if (do_fill) begin
                valid[victim_q][fill_idx] <= 1'b1;
                plru[fill_idx]            <= plru_fill_nxt;
            end
            if (do_hit) plru[idx] <= plru_hit_nxt;
            if (flush_now) begin
                for (int w = 0; w < WAYS; w++) valid[w] <= '0;
                for (int s = 0; s < SETS; s++) plru[s] <= '0;
            end
        end
    end

    // Tag and data carry no reset; valid bits alone decide a hit.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_arr[victim_q][fill_idx]  <= line_q[11:IW];
            data_arr[victim_q][fill_idx] <= l2_rdata;
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway (WAYS=2, SETS=8); flush scenarios run when ICACHE_FLUSH_EN is defined.
module tb_icache_nway;
    localparam int WAYS = 2;
    localparam int SETS = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0;
    logic [15:0]  mem_address = '0;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         l2_read;
    logic [15:0]  l2_address;
    logic [127:0] l2_rdata = '0;
    logic         l2_resp = 1'b0;
`ifdef ICACHE_FLUSH_EN
    logic         flush = 1'b0;
`endif

    icache_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .l2_read     (l2_read),
        .l2_address  (l2_address),
        .l2_rdata    (l2_rdata),
        .l2_resp     (l2_resp)
`ifdef ICACHE_FLUSH_EN
        ,
        .flush       (flush)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    // L2 backing store: a fixed pattern per line, with word3 of line 0x123 = 0xBEEF.
    function automatic logic [127:0] line_of(input logic [11:0] la);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[k*16 +: 16] = {la, 4'(k)} ^ 16'h5A5A;
        if (la == 12'h123) l[63:48] = 16'hBEEF;
        return l;
    endfunction

    function automatic logic [15:0] word_of(input logic [15:0] a);
        logic [127:0] l;
        l = line_of(a[15:4]);
        return l[int'(a[3:1])*16 +: 16];
    endfunction

    // Holds mem_read on one address and plays L2 with the given latency until mem_resp (bounded).
    task automatic fetch(input logic [15:0] a, input int lat, output bit got, output int cyc,
                         output logic [15:0] rd, output bit l2_seen, output logic [15:0] l2a,
                         output bit busy_at_resp);
        int rd_cnt;
        rd_cnt = 0;
        got = 0; cyc = 0; rd = '0; l2_seen = 0; l2a = '0; busy_at_resp = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            mem_read = 1'b1;
            mem_address = a;
            #1;
            if (l2_read) begin
                if (!l2_seen) l2a = l2_address;
                l2_seen = 1;
                rd_cnt++;
            end
            if (l2_read && rd_cnt == lat + 1) begin
                l2_resp = 1'b1;
                l2_rdata = line_of(l2_address[15:4]);
            end else begin
                l2_resp = 1'b0;
            end
            #1;
            if (mem_resp) begin
                got = 1; cyc = c; rd = mem_rdata; busy_at_resp = l2_read;
            end
        end
        @(negedge clk);
        mem_read = 1'b0;
        l2_resp = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_read = 1'b1;
        mem_address = 16'h1230;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (mem_resp !== 1'b0) begin miscompares++; $display("FAIL reset_mem_resp: got %b expected 0", mem_resp); end
        vectors++;
        if (l2_read !== 1'b0) begin miscompares++; $display("FAIL reset_l2_read: got %b expected 0", l2_read); end
        @(negedge clk);
        rst = 1'b0;
        mem_read = 1'b0;
    endtask

    task automatic test_cold_miss;
        bit got, seen, busy; int cyc; logic [15:0] rd, l2a, ex_w;
        exp_q.push_back(16'hBEEF);
        fetch(16'h1236, 3, got, cyc, rd, seen, l2a, busy);
        vectors++;
        if (l2a !== 16'h1230) begin miscompares++; $display("FAIL cold_l2_address: got %h expected 1230", l2a); end
        vectors++;
        if (cyc !== 5) begin miscompares++; $display("FAIL cold_latency: got %0d expected 5", cyc); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL cold_l2_read_drop: got %b expected 0", busy); end
        ex_w = exp_q.pop_front();
        vectors++;
        if (got !== 1'b1 || rd !== ex_w) begin miscompares++; $display("FAIL cold_rdata: got %h (resp %b) expected %h", rd, got, ex_w); end
    endtask

    task automatic test_hit;
        bit got, seen, busy; int cyc; logic [15:0] rd, l2a, ex_w;
        logic [15:0] addrs [4];
        addrs = '{16'h1230, 16'h123E, 16'h1238, 16'h1237};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(word_of(addrs[i]));
            fetch(addrs[i], 3, got, cyc, rd, seen, l2a, busy);
            vectors++;
            if (cyc !== 0 || seen !== 1'b0) begin miscompares++; $display("FAIL hit_latency %h: got cyc %0d l2 %b expected 0/0", addrs[i], cyc, seen); end
            ex_w = exp_q.pop_front();
            vectors++;
            if (got !== 1'b1 || rd !== ex_w) begin miscompares++; $display("FAIL hit_rdata %h: got %h expected %h", addrs[i], rd, ex_w); end
        end
    endtask

    task automatic test_lru;
        bit got, seen, busy; int cyc; logic [15:0] rd, l2a, ex_w;
        logic [15:0] addrs [6];
        bit hits [6];
        addrs = '{16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000, 16'h0080};
        hits  = '{0, 0, 1, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(word_of(addrs[i]));
            fetch(addrs[i], 1, got, cyc, rd, seen, l2a, busy);
            vectors++;
            if (seen !== !hits[i] || cyc !== (hits[i] ? 0 : 3)) begin
                miscompares++;
                $display("FAIL lru_step%0d %h: got miss %b cyc %0d expected miss %b", i, addrs[i], seen, cyc, !hits[i]);
            end
            ex_w = exp_q.pop_front();
            vectors++;
            if (got !== 1'b1 || rd !== ex_w) begin miscompares++; $display("FAIL lru_rdata%0d: got %h expected %h", i, rd, ex_w); end
        end
    endtask

    task automatic test_fill_ignores_cpu;
        bit got, seen, busy; int cyc; logic [15:0] rd, l2a, ex_w;
        @(negedge clk); mem_read = 1'b1; mem_address = 16'h2224; #1;
        vectors++;
        if (mem_resp !== 1'b0) begin miscompares++; $display("FAIL ign_miss_resp: got %b expected 0", mem_resp); end
        @(negedge clk); mem_read = 1'b0; mem_address = 16'h1230; #1;
        vectors++;
        if (l2_read !== 1'b1 || l2_address !== 16'h2220) begin miscompares++; $display("FAIL ign_l2_req: got %b/%h expected 1/2220", l2_read, l2_address); end
        @(negedge clk); mem_read = 1'b1; mem_address = 16'h1230; #1;
        vectors++;
        if (mem_resp !== 1'b0 || l2_address !== 16'h2220) begin miscompares++; $display("FAIL ign_fill_hold: got resp %b addr %h expected 0/2220", mem_resp, l2_address); end
        @(negedge clk); mem_read = 1'b0; l2_resp = 1'b1; l2_rdata = line_of(12'h222);
        @(negedge clk); l2_resp = 1'b0; #1;
        vectors++;
        if (l2_read !== 1'b0) begin miscompares++; $display("FAIL ign_l2_drop: got %b expected 0", l2_read); end
        exp_q.push_back(word_of(16'h2224));
        fetch(16'h2224, 2, got, cyc, rd, seen, l2a, busy);
        vectors++;
        if (cyc !== 0 || seen !== 1'b0) begin miscompares++; $display("FAIL ign_fill_written: got cyc %0d l2 %b expected 0/0", cyc, seen); end
        ex_w = exp_q.pop_front();
        vectors++;
        if (got !== 1'b1 || rd !== ex_w) begin miscompares++; $display("FAIL ign_rdata: got %h expected %h", rd, ex_w); end
    endtask

    task automatic test_reset_mid_fill;
        bit got, seen, busy; int cyc; logic [15:0] rd, l2a, ex_w;
        @(negedge clk); mem_read = 1'b1; mem_address = 16'h4560;
        @(negedge clk); #1;
        vectors++;
        if (l2_read !== 1'b1) begin miscompares++; $display("FAIL rmf_l2_read: got %b expected 1", l2_read); end
        @(negedge clk); rst = 1'b1; #1;
        vectors++;
        if (l2_read !== 1'b0 || mem_resp !== 1'b0) begin miscompares++; $display("FAIL rmf_async: got l2 %b resp %b expected 0/0", l2_read, mem_resp); end
        @(negedge clk); rst = 1'b0; mem_read = 1'b0;
        @(negedge clk); l2_resp = 1'b1; l2_rdata = line_of(12'h456);
        @(negedge clk); l2_resp = 1'b0;
        exp_q.push_back(word_of(16'h4560));
        fetch(16'h4560, 2, got, cyc, rd, seen, l2a, busy);
        vectors++;
        if (seen !== 1'b1 || cyc !== 4) begin miscompares++; $display("FAIL rmf_not_written: got miss %b cyc %0d expected 1/4", seen, cyc); end
        ex_w = exp_q.pop_front();
        vectors++;
        if (got !== 1'b1 || rd !== ex_w) begin miscompares++; $display("FAIL rmf_rdata: got %h expected %h", rd, ex_w); end
        exp_q.push_back(word_of(16'h1230));
        fetch(16'h1230, 1, got, cyc, rd, seen, l2a, busy);
        vectors++;
        if (seen !== 1'b1) begin miscompares++; $display("FAIL rmf_cold_after_reset: got miss %b expected 1", seen); end
        ex_w = exp_q.pop_front();
        vectors++;
        if (got !== 1'b1 || rd !== ex_w) begin miscompares++; $display("FAIL rmf_rdata2: got %h expected %h", rd, ex_w); end
    endtask

`ifdef ICACHE_FLUSH_EN
    task automatic test_flush;
        bit got, seen, busy; int cyc; logic [15:0] rd, l2a, ex_w;
        exp_q.push_back(word_of(16'h1232));
        @(negedge clk); flush = 1'b1; mem_read = 1'b1; mem_address = 16'h1232; #1;
        ex_w = exp_q.pop_front();
        vectors++;
        if (mem_resp !== 1'b1 || mem_rdata !== ex_w) begin miscompares++; $display("FAIL flush_cycle_hit: got resp %b data %h expected 1/%h", mem_resp, mem_rdata, ex_w); end
        @(negedge clk); flush = 1'b0; mem_read = 1'b0;
        exp_q.push_back(word_of(16'h1230));
        fetch(16'h1230, 1, got, cyc, rd, seen, l2a, busy);
        ex_w = exp_q.pop_front();
        vectors++;
        if (seen !== 1'b1 || got !== 1'b1 || rd !== ex_w) begin miscompares++; $display("FAIL flush_idle_miss: got miss %b data %h expected 1/%h", seen, rd, ex_w); end

        exp_q.push_back(word_of(16'h5674));
        @(negedge clk); mem_read = 1'b1; mem_address = 16'h5674;
        @(negedge clk); flush = 1'b1; #1;
        vectors++;
        if (l2_read !== 1'b1) begin miscompares++; $display("FAIL flush_fill_l2: got %b expected 1", l2_read); end
        @(negedge clk); flush = 1'b0; l2_resp = 1'b1; l2_rdata = line_of(12'h567);
        @(negedge clk); l2_resp = 1'b0; #1;
        ex_w = exp_q.pop_front();
        vectors++;
        if (mem_resp !== 1'b1 || mem_rdata !== ex_w) begin miscompares++; $display("FAIL flush_fill_written: got resp %b data %h expected 1/%h", mem_resp, mem_rdata, ex_w); end
        @(negedge clk); mem_read = 1'b0;
        exp_q.push_back(word_of(16'h5674));
        fetch(16'h5674, 1, got, cyc, rd, seen, l2a, busy);
        ex_w = exp_q.pop_front();
        vectors++;
        if (seen !== 1'b1 || rd !== ex_w) begin miscompares++; $display("FAIL flush_pending_miss: got miss %b data %h expected 1/%h", seen, rd, ex_w); end
        exp_q.push_back(word_of(16'h1230));
        fetch(16'h1230, 1, got, cyc, rd, seen, l2a, busy);
        ex_w = exp_q.pop_front();
        vectors++;
        if (seen !== 1'b1 || rd !== ex_w) begin miscompares++; $display("FAIL flush_pending_miss2: got miss %b data %h expected 1/%h", seen, rd, ex_w); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_lru();
        test_fill_ignores_cpu();
        test_reset_mid_fill();
`ifdef ICACHE_FLUSH_EN
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
